// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous first-word-fall-through FIFO between host logic and the UART
//   transmitter. Absorbs bursts of bytes and hands them one at a time to the
//   transmitter. Reports fill level, almost-full and a sticky overflow flag.
//
// Ports
//   clk          system clock
//   rstn         asynchronous reset, active low
//   s_tdata      write data from host
//   s_tvalid     write request from host
//   s_tready     FIFO can accept a word (not full)
//   m_tdata      head-of-FIFO word, drives transmitter tdata
//   m_tvalid     head word valid, drives transmitter tdata_valid
//   m_tready     transmitter uart_tx_ready
//   flush        synchronous clear of all stored words and of overflow
//   fifo_count   words currently stored, 0..DEPTH
//   almost_full  fifo_count >= AFULL_LEVEL
//   overflow     sticky: a write was attempted while full
//
// Handshake: a word moves on a rising clk edge only when valid and ready are
// both high at that edge. valid never waits for ready; ready and valid are
// decoded from the registered count, so there is no combinational path from
// s_tvalid to s_tready or from m_tready to m_tvalid. m_tdata is held stable
// while m_tvalid=1 and m_tready=0.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DATA_BITS   = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [DATA_BITS-1:0]       s_tdata,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   output logic [DATA_BITS-1:0]       m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       almost_full,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LEVEL);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count_q;
   logic                 overflow_q;
   logic                 wr_en;
   logic                 rd_en;

   // Status is decoded from the count register only; reset of the count
   // therefore drops m_tvalid asynchronously.
   assign s_tready    = (count_q != FULL_CNT);
   assign m_tvalid    = (count_q != '0);
   assign almost_full = (count_q >= AFULL_CNT);
   assign fifo_count  = count_q;
   assign overflow    = overflow_q;
   assign m_tdata     = mem[rd_ptr];

   // Flush wins over any transfer in the same cycle. A read does not free a
   // slot for a write in the same cycle because s_tready comes from the count.
   assign wr_en = s_tvalid & s_tready & ~flush;
   assign rd_en = m_tvalid & m_tready & ~flush;

   // Storage array carries no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= s_tdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         // Dropped word is discarded; stored data is left untouched.
         if (s_tvalid && !s_tready) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed self-checking bench for uart_tx_fifo (DATA_BITS=8, DEPTH=16,
//   AFULL_LEVEL=12). Inputs change 1 ns after the rising edge; outputs are
//   checked at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

   logic       clk;
   logic       rstn;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tready;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready;
   logic       flush;
   logic [4:0] fifo_count;
   logic       almost_full;
   logic       overflow;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   uart_tx_fifo #(.DATA_BITS(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .flush       (flush),
      .fifo_count  (fifo_count),
      .almost_full (almost_full),
      .overflow    (overflow)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0; flush = 1'b0;
      tick(); tick();
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else pass_cnt++;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got %b exp 0", m_tvalid); else pass_cnt++;
      total_cnt++; if (s_tready !== 1'b1) $display("FAIL reset_s_tready got %b exp 1", s_tready); else pass_cnt++;
      total_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full got %b exp 0", almost_full); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else pass_cnt++;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      vals[0] = 8'h41; vals[1] = 8'h42; vals[2] = 8'h43;
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1; s_tdata = vals[i];
         tick();
         if (i == 0) begin
            total_cnt++; if (m_tvalid !== 1'b1) $display("FAIL basic_latency got %b exp 1", m_tvalid); else pass_cnt++;
         end
      end
      s_tvalid = 1'b0;
      total_cnt++; if (fifo_count !== 5'd3) $display("FAIL basic_count got %0d exp 3", fifo_count); else pass_cnt++;
      total_cnt++; if (m_tdata !== 8'h41) $display("FAIL basic_head got %h exp 41", m_tdata); else pass_cnt++;
      tick();
      total_cnt++; if (m_tdata !== 8'h41) $display("FAIL basic_hold got %h exp 41", m_tdata); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         m_tready = 1'b1;
         total_cnt++; if (m_tdata !== vals[i]) $display("FAIL basic_read%0d got %h exp %h", i, m_tdata, vals[i]); else pass_cnt++;
         tick();
         m_tready = 1'b0;
      end
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL basic_empty_count got %0d exp 0", fifo_count); else pass_cnt++;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL basic_empty_valid got %b exp 0", m_tvalid); else pass_cnt++;
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(i);
         exp_q.push_back(8'(i));
         tick();
         total_cnt++;
         if (almost_full !== ((i + 1) >= 12)) $display("FAIL fill_afull%0d got %b exp %b", i, almost_full, ((i + 1) >= 12));
         else pass_cnt++;
      end
      s_tvalid = 1'b0;
      total_cnt++; if (s_tready !== 1'b0) $display("FAIL fill_s_tready got %b exp 0", s_tready); else pass_cnt++;
      total_cnt++; if (fifo_count !== 5'd16) $display("FAIL fill_count got %0d exp 16", fifo_count); else pass_cnt++;
      s_tvalid = 1'b1; s_tdata = 8'hEE;
      tick();
      s_tvalid = 1'b0;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else pass_cnt++;
      total_cnt++; if (fifo_count !== 5'd16) $display("FAIL ovf_count got %0d exp 16", fifo_count); else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         m_tready = 1'b1;
         exp_v = exp_q.pop_front();
         total_cnt++; if (m_tdata !== exp_v) $display("FAIL fill_read%0d got %h exp %h", i, m_tdata, exp_v); else pass_cnt++;
         tick();
      end
      m_tready = 1'b0;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else pass_cnt++;
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL fill_drain_count got %0d exp 0", fifo_count); else pass_cnt++;
   endtask

   // Pointers start at 3 here, so the 15 writes and 15 reads wrap both.
   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h20 + i);
         exp_q.push_back(8'(8'h20 + i));
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h30 + k); m_tready = 1'b1;
         exp_v = exp_q.pop_front();
         total_cnt++; if (m_tdata !== exp_v) $display("FAIL b2b_read%0d got %h exp %h", k, m_tdata, exp_v); else pass_cnt++;
         exp_q.push_back(8'(8'h30 + k));
         tick();
         total_cnt++; if (fifo_count !== 5'd5) $display("FAIL b2b_count%0d got %0d exp 5", k, fifo_count); else pass_cnt++;
      end
      s_tvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_v = exp_q.pop_front();
         total_cnt++; if (m_tdata !== exp_v) $display("FAIL b2b_drain%0d got %h exp %h", i, m_tdata, exp_v); else pass_cnt++;
         tick();
      end
      m_tready = 1'b0;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL b2b_empty got %b exp 0", m_tvalid); else pass_cnt++;
   endtask

   task automatic test_flush_idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL flush_ovf got %b exp 0", overflow); else pass_cnt++;
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL flush_count got %0d exp 0", fifo_count); else pass_cnt++;
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h80 + i);
         exp_q.push_back(8'(8'h80 + i));
         tick();
      end
      s_tdata = 8'hFF; m_tready = 1'b1;
      exp_v = exp_q.pop_front();
      total_cnt++; if (m_tdata !== exp_v) $display("FAIL full_rw_head got %h exp %h", m_tdata, exp_v); else pass_cnt++;
      tick();
      s_tvalid = 1'b0; m_tready = 1'b0;
      total_cnt++; if (fifo_count !== 5'd15) $display("FAIL full_rw_count got %0d exp 15", fifo_count); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL full_rw_ovf got %b exp 1", overflow); else pass_cnt++;
      m_tready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         exp_v = exp_q.pop_front();
         total_cnt++; if (m_tdata !== exp_v) $display("FAIL full_rw_read%0d got %h exp %h", i, m_tdata, exp_v); else pass_cnt++;
         tick();
      end
      m_tready = 1'b0;
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL full_rw_drain got %0d exp 0", fifo_count); else pass_cnt++;
   endtask

   task automatic test_flush_priority();
      for (int i = 0; i < 16; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h60 + i);
         tick();
      end
      tick();
      s_tvalid = 1'b0; m_tready = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      m_tready = 1'b0;
      total_cnt++; if (fifo_count !== 5'd7) $display("FAIL fp_pre_count got %0d exp 7", fifo_count); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL fp_pre_ovf got %b exp 1", overflow); else pass_cnt++;
      flush = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h99; m_tready = 1'b1;
      tick();
      flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL fp_count got %0d exp 0", fifo_count); else pass_cnt++;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL fp_valid got %b exp 0", m_tvalid); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL fp_ovf got %b exp 0", overflow); else pass_cnt++;
      tick();
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL fp_nostore got %0d exp 0", fifo_count); else pass_cnt++;
      s_tvalid = 1'b1; s_tdata = 8'h5A;
      tick();
      s_tvalid = 1'b0;
      total_cnt++; if (m_tdata !== 8'h5A) $display("FAIL fp_after got %h exp 5a", m_tdata); else pass_cnt++;
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL fp_after_count got %0d exp 0", fifo_count); else pass_cnt++;
   endtask

   task automatic test_reset_mid_op();
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'hC0 + i);
         tick();
      end
      s_tvalid = 1'b0;
      total_cnt++; if (fifo_count !== 5'd3) $display("FAIL rmid_pre got %0d exp 3", fifo_count); else pass_cnt++;
      rstn = 1'b0;
      #1;
      total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", m_tvalid); else pass_cnt++;
      total_cnt++; if (fifo_count !== 5'd0) $display("FAIL rmid_count got %0d exp 0", fifo_count); else pass_cnt++;
      tick();
      rstn = 1'b1;
      tick();
      total_cnt++; if (s_tready !== 1'b1) $display("FAIL rmid_ready got %b exp 1", s_tready); else pass_cnt++;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic();
      test_fill_overflow();
      test_back_to_back();
      test_flush_idle();
      test_full_rw();
      test_flush_priority();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
